macc_pipe: RTL and testbench
============================

MACC_PIPE -- requirements
Module: macc_pipe

Interface
REQ-001 SHALL have parameter SIZEIN, default 16, meaning operand width in bits (signed).
REQ-002 SHALL have parameter SIZEOUT, default 40, meaning accumulator and partial-sum width in bits (signed).
REQ-003 SHALL have parameter LANES, default 4, meaning multiplier lanes summed per beat (power of 2, 1..16).
REQ-004 SHALL have parameter CNT_W, default 8, meaning beat-counter width.
REQ-005 SHALL have parameter SAT, default 1, meaning 1 = saturating accumulate, 0 = two's-complement wrap.
REQ-006 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-008 SHALL have port clear  in  1  synchronous abort of the current group.
REQ-009 SHALL have port cfg_len  in  CNT_W  beats per group, sampled on the first beat of a group.
REQ-010 SHALL have port in_valid / in_ready  in / out  1 each  input handshake.
REQ-011 SHALL have port in_a, in_b  in  LANES*SIZEIN  packed signed operands; lane i occupies bits [i*SIZEIN +: SIZEIN].
REQ-012 SHALL have port in_gate  in  LANES  per-lane zero-skip; a set bit forces that lane's product to 0.
REQ-013 SHALL have port exter  in  1  seed select, sampled on the first beat of a group.
REQ-014 SHALL have port external_psum  in  SIZEOUT  signed seed, sampled on the first beat of a group.
REQ-015 SHALL have port out_valid / out_ready  out / in  1 each  output handshake.
REQ-016 SHALL have port accum_out  out  SIZEOUT  signed group result.
REQ-017 SHALL have port out_sat  out  1  set if any accumulate step of the group saturated.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready.
REQ-019 SHALL define en = !(out_valid && !out_ready) && !clear, and SHALL drive in_ready = en.
REQ-020 SHALL advance all pipeline stages only when en=1; when en=0, every stage SHALL hold.
REQ-021 SHALL use a three-stage pipeline:
  - S1 registers the LANES products, each 2*SIZEIN bits, with gated lanes forced to 0.
  - S2 registers the lane sum at full width, 2*SIZEIN+log2(LANES) bits, sign-extended.
  - S3 updates the accumulator.
REQ-022 SHALL carry valid, first and last tags alongside the data through S1 and S2.
REQ-023 SHALL use a beat counter: first = (cnt==0); last = (cnt==len-1); cnt wraps to 0 after last; cfg_len=0 is treated as 1.
REQ-024 SHALL have exactly two counter states, IDLE (cnt==0) and BUSY (cnt!=0), with no other control states.
REQ-025 On a first-tagged beat, S3 SHALL compute acc = seed + sum, where seed = exter ? external_psum : 0 (values captured at S0); otherwise S3 SHALL compute acc = acc + sum.
REQ-026 S3 SHALL compute the addition at SIZEOUT+1 bits.
REQ-027 With SAT=1, S3 SHALL clamp the result to [-2^(SIZEOUT-1), 2^(SIZEOUT-1)-1] and set the group's sticky saturation flag; with SAT=0, S3 SHALL truncate and the flag SHALL stay 0.
REQ-028 On a last-tagged beat, S3 SHALL load accum_out and out_sat and set out_valid.
REQ-029 SHALL hold out_valid, accum_out and out_sat stable until out_ready is high.
REQ-030 SHALL clear out_valid on handshake, unless a new last-tagged beat completes in the same cycle, in which case out_valid SHALL remain 1 with the new data.
REQ-031 Latency SHALL be: last beat accepted at edge t gives out_valid at edge t+3 with no backpressure; single-beat groups SHALL stream at 1 result/cycle.
REQ-032 clear SHALL take priority over everything except rst_n and SHALL:
  - zero cnt;
  - drop S1/S2 valid bits;
  - drop out_valid;
  - leave the acc contents don't-care;
  - accept no beat that cycle.
REQ-033 Back-to-back groups SHALL need no idle cycle; a first-tagged beat in S3 SHALL not depend on the prior acc value.

Reset
REQ-034 With rst_n=0 at a clk edge, the block SHALL set:
  - out_valid = 0, accum_out = 0, out_sat = 0;
  - cnt = 0, all stage valid bits = 0, acc = 0, sticky flag = 0.
REQ-035 Reset mid-group SHALL discard the partial group, with no output produced for it.
REQ-036 in_ready SHALL be 0 while rst_n=0.

Structure
REQ-037 Package macc_pkg SHALL hold:
  - parameter defaults;
  - a tree-width localparam function;
  - the saturate helper function.
REQ-038 SHALL contain one sub-module, macc_add_tree: combinational signed LANES-input adder, instantiated between S1 and S2.

Verification
REQ-039 SHALL cover: LANES=4, cfg_len=1, a={1,2,3,4}, b={5,6,7,8}, exter=0 -> accum_out=70 three cycles after acceptance, out_sat=0.
REQ-040 SHALL cover: cfg_len=3, all lanes a=b=-32768, exter=1, external_psum=-100 -> accum_out = 3*4*2^30 - 100 = 12884901788.
REQ-041 SHALL cover: in_gate=4'b0101 with a=b=all 10 -> accum_out=200.
REQ-042 SHALL cover: SAT=1, SIZEOUT=40, external_psum=2^39-10, product sum +100 -> accum_out=2^39-1, out_sat=1; SAT=0 -> wrapped value, out_sat=0.
REQ-043 SHALL cover: out_ready=0 for 5 cycles with 3 single-beat groups streamed -> in_ready drops; no result lost or duplicated; order preserved.
REQ-044 SHALL cover: clear (or rst_n=0) asserted after beat 2 of a 4-beat group -> no out_valid; the next group's result is correct.

Source files
------------

// File: rtl/macc_pkg.sv
// Shared defaults, state/result types and arithmetic helpers for the MAC pipeline.
package macc_pkg;

  localparam int unsigned DEF_SIZEIN  = 16;
  localparam int unsigned DEF_SIZEOUT = 40;
  localparam int unsigned DEF_LANES   = 4;
  localparam int unsigned DEF_CNT_W   = 8;
  localparam bit          DEF_SAT     = 1'b1;

  // Widest accumulator the saturate helper supports (SIZEOUT must be below this).
  localparam int unsigned SAT_MAXW = 64;

  typedef enum logic {
    IDLE,
    BUSY
  } cnt_state_e;

  typedef struct packed {
    logic                ovf;
    logic [SAT_MAXW-1:0] val;
  } sat_res_t;

  function automatic int unsigned tree_w(input int unsigned sizein, input int unsigned lanes);
    return 2 * sizein + $clog2(lanes);
  endfunction

  // wide is a sign-extended (w+1)-bit sum; clamp it into the signed w-bit range.
  function automatic sat_res_t saturate(input logic [SAT_MAXW:0] wide, input int unsigned w);
    sat_res_t                   r;
    logic signed [SAT_MAXW:0]   hi;
    logic signed [SAT_MAXW:0]   lo;
    hi = {1'b0, (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1)};
    lo = ~hi;
    if ($signed(wide) > hi) begin
      r.ovf = 1'b1;
      r.val = hi[SAT_MAXW-1:0];
    end else if ($signed(wide) < lo) begin
      r.ovf = 1'b1;
      r.val = lo[SAT_MAXW-1:0];
    end else begin
      r.ovf = 1'b0;
      r.val = wide[SAT_MAXW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/macc_pipe_add_tree.sv
// Combinational signed adder summing LANES packed products at full growth width.
module macc_add_tree
  import macc_pkg::*;
#(
  parameter int unsigned SIZEIN = DEF_SIZEIN,
  parameter int unsigned LANES  = DEF_LANES,
  localparam int unsigned PW    = 2 * SIZEIN,
  localparam int unsigned TW    = tree_w(SIZEIN, LANES)
) (
  input  logic [LANES*PW-1:0] prod,
  output logic [TW-1:0]       sum
);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum = sum + TW'($signed(prod[i*PW +: PW]));
    end
  end

endmodule

// File: rtl/macc_pipe.sv
// Multi-lane multiply-accumulate pipeline: S0 input capture, S1 products,
// S2 lane sum, S3 grouped accumulate with optional saturation and a result hold register.
module macc_pipe
  import macc_pkg::*;
#(
  parameter int unsigned SIZEIN  = DEF_SIZEIN,
  parameter int unsigned SIZEOUT = DEF_SIZEOUT,
  parameter int unsigned LANES   = DEF_LANES,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter bit          SAT     = DEF_SAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [CNT_W-1:0]          cfg_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*SIZEIN-1:0]   in_a,
  input  logic [LANES*SIZEIN-1:0]   in_b,
  input  logic [LANES-1:0]          in_gate,
  input  logic                      exter,
  input  logic [SIZEOUT-1:0]        external_psum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIZEOUT-1:0]        accum_out,
  output logic                      out_sat
);

  localparam int unsigned PW = 2 * SIZEIN;
  localparam int unsigned TW = tree_w(SIZEIN, LANES);
  localparam int unsigned AW = SIZEOUT + 1;

  logic en, accept;
  assign en       = !(out_valid && !out_ready) && !clear;
  assign in_ready = en && rst_n;
  assign accept   = in_valid && in_ready;

  cnt_state_e       state;
  logic [CNT_W-1:0] cnt, len_q, len_eff;
  logic             first, last;

  // state mirrors cnt==0 so the first-beat decode stays a single flop
  always_comb begin
    first   = (state == IDLE);
    len_eff = first ? ((cfg_len == '0) ? CNT_W'(1) : cfg_len) : len_q;
    last    = (cnt == len_eff - CNT_W'(1));
  end

  logic                      s0_valid, s0_first, s0_last;
  logic [LANES*SIZEIN-1:0]   s0_a, s0_b;
  logic [LANES-1:0]          s0_gate;
  logic [SIZEOUT-1:0]        s0_seed;

  logic                      s1_valid, s1_first, s1_last;
  logic [LANES*PW-1:0]       s1_prod, prod_d;
  logic [SIZEOUT-1:0]        s1_seed;

  logic                      s2_valid, s2_first, s2_last;
  logic [TW-1:0]             s2_sum, tree_sum;
  logic [SIZEOUT-1:0]        s2_seed;

  logic [SIZEOUT-1:0]        acc;
  logic                      sticky;

  always_comb begin
    prod_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!s0_gate[i]) begin
        prod_d[i*PW +: PW] = PW'($signed(s0_a[i*SIZEIN +: SIZEIN]))
                           * PW'($signed(s0_b[i*SIZEIN +: SIZEIN]));
      end
    end
  end

  macc_add_tree #(
    .SIZEIN (SIZEIN),
    .LANES  (LANES)
  ) u_add_tree (
    .prod (s1_prod),
    .sum  (tree_sum)
  );

  logic [AW-1:0]       base_ext, sum_ext, wide;
  logic [SIZEOUT-1:0]  acc_next;
  logic                ovf, sticky_next;
  sat_res_t            sr;
  logic                unused_bits;

  // First-tagged beats restart from the seed, so the previous acc never leaks in.
  always_comb begin
    base_ext = s2_first ? {s2_seed[SIZEOUT-1], s2_seed} : {acc[SIZEOUT-1], acc};
    sum_ext  = {{(AW-TW){s2_sum[TW-1]}}, s2_sum};
    wide     = base_ext + sum_ext;
    sr       = saturate({{(SAT_MAXW-SIZEOUT){wide[AW-1]}}, wide}, SIZEOUT);
    if (SAT) begin
      acc_next = sr.val[SIZEOUT-1:0];
      ovf      = sr.ovf;
    end else begin
      acc_next = wide[SIZEOUT-1:0];
      ovf      = 1'b0;
    end
    sticky_next = (s2_first ? 1'b0 : sticky) | ovf;
  end

  assign unused_bits = ^sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      s0_valid  <= 1'b0;
      s0_first  <= 1'b0;
      s0_last   <= 1'b0;
      s0_a      <= '0;
      s0_b      <= '0;
      s0_gate   <= '0;
      s0_seed   <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod   <= '0;
      s1_seed   <= '0;
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_sum    <= '0;
      s2_seed   <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      accum_out <= '0;
      out_sat   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      s0_valid  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (accept) begin
        if (first) len_q <= len_eff;
        if (last) begin
          cnt   <= '0;
          state <= IDLE;
        end else begin
          cnt   <= cnt + CNT_W'(1);
          state <= BUSY;
        end
      end
      s0_valid <= accept;
      s0_first <= first;
      s0_last  <= last;
      s0_a     <= in_a;
      s0_b     <= in_b;
      s0_gate  <= in_gate;
      s0_seed  <= exter ? external_psum : '0;

      s1_valid <= s0_valid;
      s1_first <= s0_first;
      s1_last  <= s0_last;
      s1_prod  <= prod_d;
      s1_seed  <= s0_seed;

      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sum   <= tree_sum;
      s2_seed  <= s1_seed;

      if (s2_valid) begin
        acc    <= acc_next;
        sticky <= sticky_next;
      end
      // en implies any pending result is being taken this cycle
      if (s2_valid && s2_last) begin
        out_valid <= 1'b1;
        accum_out <= acc_next;
        out_sat   <= sticky_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_macc_pipe.sv
// Self-checking bench for macc_pipe: saturating and wrapping instances in lockstep,
// table-driven single-beat groups, hand-written multi-cycle sequences, scoreboard on output.
module tb_macc_pipe;

  localparam int SIZEIN  = 16;
  localparam int SIZEOUT = 40;
  localparam int LANES   = 4;
  localparam int CNT_W   = 8;
  localparam longint MAXV = 64'sd549755813887;
  localparam longint MINV = -64'sd549755813888;

  logic clk = 1'b0;
  logic rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, exter = 1'b0, out_ready = 1'b1;
  logic [CNT_W-1:0]        cfg_len = '0;
  logic [LANES*SIZEIN-1:0] in_a = '0, in_b = '0;
  logic [LANES-1:0]        in_gate = '0;
  logic [SIZEOUT-1:0]      external_psum = '0;
  logic                    in_ready, out_valid, out_sat;
  logic [SIZEOUT-1:0]      accum_out;
  logic                    in_ready_w, out_valid_w, out_sat_w;
  logic [SIZEOUT-1:0]      accum_out_w;

  always #5 clk = ~clk;

  macc_pipe #(.SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .LANES(LANES), .CNT_W(CNT_W), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_gate(in_gate),
    .exter(exter), .external_psum(external_psum),
    .out_valid(out_valid), .out_ready(out_ready), .accum_out(accum_out), .out_sat(out_sat));

  macc_pipe #(.SIZEIN(SIZEIN), .SIZEOUT(SIZEOUT), .LANES(LANES), .CNT_W(CNT_W), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_a(in_a), .in_b(in_b), .in_gate(in_gate),
    .exter(exter), .external_psum(external_psum),
    .out_valid(out_valid_w), .out_ready(out_ready), .accum_out(accum_out_w), .out_sat(out_sat_w));

  typedef struct { longint val_s; bit flag_s; longint val_w; } exp_t;
  typedef struct {
    logic [63:0] a, b; logic [3:0] g; bit ex; longint ps; int len;
    longint exp_s; bit exp_f; longint exp_w;
  } vec_t;

  exp_t   sb[$];
  exp_t   got;
  vec_t   tbl[7];
  int     n_pass = 0, n_total = 0;
  bit     rand_ready = 0;
  int     m_cnt = 0, m_len = 1;
  longint m_acc_s = 0, m_acc_w = 0;
  bit     m_flag = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic longint wrap40(input longint v);
    longint r;
    r = v <<< 24;
    return r >>> 24;
  endfunction

  function automatic longint lane_sum(input logic [63:0] a, input logic [63:0] b, input logic [3:0] g);
    longint s = 0;
    logic signed [15:0] x, y;
    for (int i = 0; i < 4; i++) begin
      x = a[i*16 +: 16];
      y = b[i*16 +: 16];
      if (!g[i]) s += longint'(x) * longint'(y);
    end
    return s;
  endfunction

  task automatic model_step(input logic [63:0] a, input logic [63:0] b, input logic [3:0] g,
                            input bit ex, input longint ps, input int len, input bit push);
    longint s, bs, bw, t;
    s = lane_sum(a, b, g);
    if (m_cnt == 0) begin
      m_len  = (len == 0) ? 1 : len;
      bs     = ex ? ps : 0;
      bw     = bs;
      m_flag = 0;
    end else begin
      bs = m_acc_s;
      bw = m_acc_w;
    end
    t = bs + s;
    if (t > MAXV) begin t = MAXV; m_flag = 1; end
    else if (t < MINV) begin t = MINV; m_flag = 1; end
    m_acc_s = t;
    m_acc_w = wrap40(bw + s);
    if (m_cnt == m_len - 1) begin
      if (push) sb.push_back('{m_acc_s, m_flag, m_acc_w});
      m_cnt = 0;
    end else m_cnt++;
  endtask

  // Called just after a posedge; returns just after the edge that accepted the beat.
  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] g,
                      input bit ex, input longint ps, input int len, input bit push);
    bit done = 0;
    in_a = a; in_b = b; in_gate = g; exter = ex;
    external_psum = SIZEOUT'(ps); cfg_len = CNT_W'(len); in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        model_step(a, b, g, ex, ps, len, push);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("beat_accept", longint'(done), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && sb.size() > 0; k++) @(posedge clk);
    check("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic watch_quiet(input string name);
    bit seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || out_valid_w) seen = 1;
    end
    check(name, longint'(seen), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: accum_out=%0d with no result expected", $signed(accum_out));
      end else begin
        got = sb.pop_front();
        check("accum_sat", $signed(accum_out), got.val_s);
        check("flag_sat", longint'(out_sat), longint'(got.flag_s));
        check("accum_wrap", $signed(accum_out_w), got.val_w);
        check("flag_wrap", longint'(out_sat_w), 0);
        check("valid_wrap", longint'(out_valid_w), 1);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{pk(1,2,3,4), pk(5,6,7,8), 4'b0000, 0, 0, 1, 70, 0, 70};
    tbl[1] = '{pk(10,10,10,10), pk(10,10,10,10), 4'b0101, 0, 0, 1, 200, 0, 200};
    tbl[2] = '{pk(10,0,0,0), pk(10,0,0,0), 4'b0000, 1, MAXV - 9, 1, MAXV, 1, -64'sd549755813798};
    tbl[3] = '{pk(-10,0,0,0), pk(10,0,0,0), 4'b0000, 1, MINV + 5, 1, MINV, 1, 64'sd549755813793};
    tbl[4] = '{pk(-3,7,-32768,100), pk(4,-2,-32768,-1), 4'b0000, 1, 1000, 1, 1073742698, 0, 1073742698};
    tbl[5] = '{pk(9,9,9,9), pk(9,9,9,9), 4'b1111, 1, -5, 1, -5, 0, -5};
    tbl[6] = '{pk(1,1,1,1), pk(2,2,2,2), 4'b0000, 0, 0, 0, 8, 0, 8};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_accum_out", longint'(accum_out), 0);
    check("rst_out_sat", longint'(out_sat), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // latency: last beat accepted at edge t, out_valid at edge t+3
    sb.push_back('{70, 0, 70});
    beat(tbl[0].a, tbl[0].b, tbl[0].g, 0, 0, 1, 0);
    repeat (3) @(negedge clk);
    check("latency_t2_low", longint'(out_valid), 0);
    @(negedge clk);
    check("latency_t3_high", longint'(out_valid), 1);
    @(posedge clk); #1;
    drain();

    // table-driven single-beat groups, streamed back to back
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{tbl[i].exp_s, tbl[i].exp_f, tbl[i].exp_w});
      beat(tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].ex, tbl[i].ps, tbl[i].len, 0);
    end
    drain();

    // three beats of all -32768 with seed -100 (12884901788)
    for (int i = 0; i < 3; i++)
      beat(pk(-32768,-32768,-32768,-32768), pk(-32768,-32768,-32768,-32768), 4'b0, 1, -100, 3, 1);
    // sticky saturation across a group
    beat(pk(10,0,0,0), pk(10,0,0,0), 4'b0, 1, MAXV - 9, 3, 1);
    beat(pk(-10,0,0,0), pk(100,0,0,0), 4'b0, 0, 0, 3, 1);
    beat(pk(5,5,5,5), pk(5,5,5,5), 4'b1111, 0, 0, 3, 1);
    // back-to-back two-beat groups
    for (int i = 0; i < 6; i++)
      beat(pk(i+1,-i,3,i*7), pk(2,5,-i,11), 4'b0010, i[0], 1000*i, 2, 1);
    drain();

    // output stall with five single-beat groups
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++)
          beat(pk(i+1,0,0,0), pk(100,0,0,0), 4'b0, 0, 0, 1, 1);
      end
      begin
        repeat (6) @(negedge clk);
        check("stall_in_ready_low", longint'(in_ready), 0);
        check("stall_out_valid_held", longint'(out_valid), 1);
        check("stall_accum_held", $signed(accum_out), 100);
        @(posedge clk); #2;
        out_ready = 1'b1;
      end
    join
    drain();

    // clear after beat 2 of a 4-beat group
    beat(pk(1,2,3,4), pk(1,1,1,1), 4'b0, 1, 5000, 4, 1);
    beat(pk(1,2,3,4), pk(1,1,1,1), 4'b0, 0, 0, 4, 1);
    clear = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("clear_in_ready_low", longint'(in_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    m_cnt = 0;
    watch_quiet("clear_no_output");
    beat(pk(3,3,3,3), pk(-4,4,-4,4), 4'b0, 1, 77, 2, 1);
    beat(pk(6,0,0,0), pk(6,0,0,0), 4'b0, 1, -9999, 2, 1);
    drain();

    // reset after beat 2 of a 4-beat group
    beat(pk(7,7,7,7), pk(7,7,7,7), 4'b0, 0, 0, 4, 1);
    beat(pk(7,7,7,7), pk(7,7,7,7), 4'b0, 0, 0, 4, 1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check("reset_in_ready_low", longint'(in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    m_cnt = 0;
    watch_quiet("reset_no_output");
    beat(pk(2,0,0,0), pk(21,0,0,0), 4'b0, 0, 0, 1, 1);
    drain();

    // random groups under random backpressure; cfg_len/seed changes mid-group must be ignored
    rand_ready = 1;
    for (int g = 0; g < 15; g++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        longint ps;
        ps = ($urandom_range(0, 3) == 0) ? MAXV - longint'($urandom_range(0, 1 << 20))
                                         : longint'($signed($urandom));
        beat({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), ps, (k == 0) ? len : $urandom_range(0, 9), 1);
      end
    end
    rand_ready = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
